// File: rtl/register_bank.sv
// DEPTH x WIDTH register bank with one write port and two registered, write-first
// read ports. Each entry has a valid bit, and a bulk clear empties the whole bank.
module register_bank #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [WIDTH-1:0]      write_data,
    input  logic                  read_enable_a,
    input  logic [ADDR_WIDTH-1:0] read_addr_a,
    output logic [WIDTH-1:0]      read_data_a,
    output logic                  read_valid_a,
    input  logic                  read_enable_b,
    input  logic [ADDR_WIDTH-1:0] read_addr_b,
    output logic [WIDTH-1:0]      read_data_b,
    output logic                  read_valid_b
);

    // One extra bit so that DEPTH == 2**ADDR_WIDTH is still representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r        [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [WIDTH-1:0] mem_next_s   [DEPTH];
    logic [DEPTH-1:0] valid_next_s;

    logic             write_in_range_s;
    logic             read_in_range_a_s;
    logic             read_in_range_b_s;
    logic [WIDTH-1:0] read_data_a_s;
    logic             read_valid_a_s;
    logic [WIDTH-1:0] read_data_b_s;
    logic             read_valid_b_s;

    // Address range qualification for the write port and both read ports.
    always_comb begin
        write_in_range_s  = ({1'b0, write_addr}  < DEPTH_W);
        read_in_range_a_s = ({1'b0, read_addr_a} < DEPTH_W);
        read_in_range_b_s = ({1'b0, read_addr_b} < DEPTH_W);
    end

    // Next-state of the array: the write wins over clear on its own entry.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (write_enable && write_in_range_s && (write_addr == ADDR_WIDTH'(i))) begin
                mem_next_s[i]   = write_data;
                valid_next_s[i] = 1'b1;
            end else if (clear) begin
                mem_next_s[i]   = {WIDTH{1'b0}};
                valid_next_s[i] = 1'b0;
            end else begin
                mem_next_s[i]   = mem_r[i];
                valid_next_s[i] = valid_r[i];
            end
        end
    end

    // Read muxes look at next-state contents, which gives write-first behaviour.
    always_comb begin
        if (read_in_range_a_s) begin
            read_data_a_s  = mem_next_s[read_addr_a];
            read_valid_a_s = valid_next_s[read_addr_a];
        end else begin
            read_data_a_s  = {WIDTH{1'b0}};
            read_valid_a_s = 1'b0;
        end
        if (read_in_range_b_s) begin
            read_data_b_s  = mem_next_s[read_addr_b];
            read_valid_b_s = valid_next_s[read_addr_b];
        end else begin
            read_data_b_s  = {WIDTH{1'b0}};
            read_valid_b_s = 1'b0;
        end
    end

    // Storage and valid vector update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            valid_r <= {DEPTH{1'b0}};
        end else begin
            mem_r   <= mem_next_s;
            valid_r <= valid_next_s;
        end
    end

    // Registered read ports; a port without read enable holds its last result.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_data_a  <= {WIDTH{1'b0}};
            read_valid_a <= 1'b0;
            read_data_b  <= {WIDTH{1'b0}};
            read_valid_b <= 1'b0;
        end else begin
            if (read_enable_a) begin
                read_data_a  <= read_data_a_s;
                read_valid_a <= read_valid_a_s;
            end
            if (read_enable_b) begin
                read_data_b  <= read_data_b_s;
                read_valid_b <= read_valid_b_s;
            end
        end
    end

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- Parametrised successor to the single-bit enabled register: a DEPTH-entry x WIDTH-bit register bank for the MAC datapath, e.g. holding operands, coefficients and partial sums.
- One write port and two independent registered read ports, each with a per-port read enable.
- A per-entry valid bit, a bulk clear, and write-first bypass from the write port to either read port in the same cycle.

Parameters:
WIDTH, 8, bits per entry (>=1)
DEPTH, 8, number of entries (>=2, need not be a power of two)
ADDR_WIDTH, 3, address bits; must satisfy 2**ADDR_WIDTH >= DEPTH

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
clear  input  1  synchronous bulk clear of all entries and valid bits
write_enable  input  1  write strobe
write_addr  input  ADDR_WIDTH  write address
write_data  input  WIDTH  write data
read_enable_a  input  1  port A read strobe
read_addr_a  input  ADDR_WIDTH  port A address
read_data_a  output  WIDTH  port A registered data
read_valid_a  output  1  port A: addressed entry was valid
read_enable_b  input  1  port B read strobe
read_addr_b  input  ADDR_WIDTH  port B address
read_data_b  output  WIDTH  port B registered data
read_valid_b  output  1  port B: addressed entry was valid

Behaviour:
- Reset has top priority. At a rising edge with reset=1:
  - every entry goes to 0 and every valid bit to 0;
  - read_data_a/b go to 0 and read_valid_a/b go to 0;
  - all other inputs are ignored that edge.
- Reset mid-operation aborts any write in the same cycle.
- Next-state of the array at each edge, with reset=0, is evaluated in this order:
  1. If clear=1, all entries go to 0 and all valid bits to 0.
  2. If write_enable=1 and write_addr<DEPTH, entry[write_addr]<=write_data and valid[write_addr]<=1.
  - Consequence: clear and write in the same cycle leaves exactly one valid entry, the written one.
- A write to an address >= DEPTH is dropped silently; no entry changes.
- Reads have a latency of one cycle.
  - At the edge where read_enable_x=1, read_data_x and read_valid_x are loaded with the next-state contents of entry[read_addr_x], i.e. after this edge's clear and write are applied.
  - This makes the ports write-first: a same-cycle write to the read address appears at the output one cycle after the request.
  - A same-cycle clear yields data 0 and valid 0.
- A read with read_enable_x=1 and read_addr_x >= DEPTH loads data 0 and valid 0.
- With read_enable_x=0, read_data_x and read_valid_x hold their previous values, including across writes to the held address.
- Ports A and B are fully independent and may read the same address in the same cycle; both receive identical data.
- No combinational path from any input to any output; all outputs come straight from flops.
- Storage is an array of WIDTH-bit registers plus a DEPTH-bit valid vector. No reset-less storage.

Test Plan:
1. Reset: hold reset=1 for 2 edges with write_enable=1, write_addr=2, write_data=8'hAA. Release reset, then read addr 2 on both ports -> data 8'h00, valid 0.
2. Write/read latency: write 8'h5C to addr 3, next cycle read_addr_a=3 with read_enable_a=1 -> one edge later read_data_a=8'h5C, read_valid_a=1. Read addr 4 on B -> 8'h00, valid 0.
3. Write-first bypass: in one cycle write 8'h11 to addr 6 (old value 8'h77) and read addr 6 on port A -> next edge read_data_a=8'h11, valid 1.
4. Clear vs write: fill addrs 0..7 with 8'h10+i. Assert clear and write 8'hEE to addr 1 in the same cycle -> addr 1 reads 8'hEE with valid 1; addrs 0 and 2..7 read 8'h00 with valid 0.
5. Hold and out-of-range with DEPTH=6, ADDR_WIDTH=3:
   - write to addr 7 -> no entry changes;
   - read addr 7 -> data 0, valid 0;
   - with read_enable_b=0, overwrite the held address -> read_data_b unchanged.
6. Random regression: 500 cycles of random writes, reads, enables and clears, with reset pulsed at a random cycle. Compare against a behavioural model every edge -> zero mismatches.
